// File: rtl/float_fmt_pkg.sv
// Shared definitions for the small-float format: 4-bit MSB-explicit mantissa,
// 3-bit left-shift exponent, 11-bit unsigned integer. Used by the encoder and
// the serial decoder.
package float_fmt_pkg;

    localparam int MW = 4;   // mantissa width
    localparam int EW = 3;   // exponent width
    localparam int IW = 11;  // integer width, at least MW + 2**EW - 1

    // Decoder control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Encoded value as produced by the int2float encoder
    typedef struct packed {
        logic [EW-1:0] e;
        logic [MW-1:0] m;
    } fp_t;

    // The encoder always normalises, so a non-zero exponent must come with
    // the mantissa MSB set; anything else could not have come from it.
    function automatic logic is_noncanon(input fp_t f);
        return (f.e != '0) && !f.m[MW-1];
    endfunction

endpackage

// File: rtl/float2int_serial_if.sv
// Input/output handshake bundle of the serial float-to-integer decoder.
// Both sides use valid/ready: a transfer happens on the rising clock edge
// where valid and ready are both high; valid, once raised, is held with its
// data stable until that edge, and valid never waits on ready.
interface float2int_serial_if;
    import float_fmt_pkg::*;

    logic          in_valid;
    logic          in_ready;
    logic [MW-1:0] in_m;
    logic [EW-1:0] in_e;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_b;
    logic          out_noncanon;

    // Decoder side
    modport slave (
        input  in_valid, in_m, in_e, out_ready,
        output in_ready, out_valid, out_b, out_noncanon
    );

    // Producer/consumer side
    modport master (
        output in_valid, in_m, in_e, out_ready,
        input  in_ready, out_valid, out_b, out_noncanon
    );

endinterface

// File: rtl/float2int_serial.sv
// Serial decoder from {E, M} back to an unsigned integer: captures the pair,
// shifts the mantissa left one bit per cycle E times, then holds the result
// on a registered valid/ready output until it is taken.
module float2int_serial
    import float_fmt_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    float2int_serial_if.slave   bus,
    output state_t              fsm_state
);

    state_t        state;
    state_t        state_next;
    logic [IW-1:0] acc;
    logic [EW-1:0] cnt;
    logic          noncanon;
    fp_t           in_word;
    logic          accept;

    assign in_word = '{e: bus.in_e, m: bus.in_m};
    assign accept  = (state == IDLE) && bus.in_valid;

    // State register; reset aborts any conversion in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: E == 0 needs no shifting, cnt == 1 is the last shift
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    state_next = (bus.in_e == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == EW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: capture on accept, shift while in SHIFT, hold otherwise so
    // the result stays visible after the output handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            cnt      <= '0;
            noncanon <= 1'b0;
        end else if (accept) begin
            acc      <= {{(IW-MW){1'b0}}, bus.in_m};
            cnt      <= bus.in_e;
            noncanon <= is_noncanon(in_word);
        end else if (state == SHIFT) begin
            acc      <= acc << 1;
            cnt      <= cnt - EW'(1);
        end
    end

    // All outputs come straight from registers
    assign bus.in_ready     = (state == IDLE);
    assign bus.out_valid    = (state == DONE);
    assign bus.out_b        = acc;
    assign bus.out_noncanon = noncanon;
    assign fsm_state        = state;

endmodule

// File: tb/tb_float2int_serial.sv
// Directed and exhaustive bench for float2int_serial. Expected results are
// computed from M << E and the canonical rule when a pair is driven, queued,
// and compared when the decoder presents its output.
module tb_float2int_serial;
    import float_fmt_pkg::*;

    localparam int W = IW + 1;

    // Clock / reset
    logic   clk = 1'b0;
    logic   rst;
    state_t fsm_state;

    always #5 clk = ~clk;

    float2int_serial_if bus ();

    float2int_serial dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    // Scoreboard: {noncanon, integer}
    logic [W-1:0] exp_q[$];
    int total  = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one pair, wait for the result, then complete the output handshake.
    // hold: cycles of out_ready low in DONE (used when early_ready is 0).
    // early_ready: raise out_ready right after accept.
    // junk: keep in_valid high with other data while busy.
    task automatic convert(input logic [MW-1:0] m, input logic [EW-1:0] e,
                           input int hold, input bit early_ready, input bit junk);
        logic [IW-1:0] b;
        logic [W-1:0]  exp;
        int            cycles;
        bit            seen;

        @(negedge clk);
        check("in_ready_idle", 32'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.in_m     = m;
        bus.in_e     = e;
        b   = IW'(m) << e;
        exp = {((e != 0) && !m[MW-1]), b};
        exp_q.push_back(exp);

        @(negedge clk);
        cycles = 1;
        if (junk) begin
            bus.in_m = ~m;
            bus.in_e = ~e;
        end else begin
            bus.in_valid = 1'b0;
        end
        if (early_ready) bus.out_ready = 1'b1;

        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.out_valid) begin
                seen = 1'b1;
                break;
            end
            check("in_ready_busy", 32'(bus.in_ready), 0);
            @(negedge clk);
            cycles++;
        end
        check("out_valid_timeout", 32'(seen), 1);
        check("latency", 32'(cycles), 32'(e) + 1);
        check("in_ready_done", 32'(bus.in_ready), 0);

        if (!early_ready) begin
            for (int i = 0; i < hold; i++) begin
                check("stall_valid", 32'(bus.out_valid), 1);
                check("stall_out_b", 32'(bus.out_b), 32'(b));
                @(negedge clk);
            end
            bus.out_ready = 1'b1;
        end

        if (exp_q.size() == 0) begin
            check("sb_empty", 0, 1);
        end else begin
            exp = exp_q.pop_front();
            check("out_b", 32'(bus.out_b), 32'(exp[IW-1:0]));
            check("out_noncanon", 32'(bus.out_noncanon), 32'(exp[IW]));
        end

        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check("out_valid_drop", 32'(bus.out_valid), 0);
        check("in_ready_rise", 32'(bus.in_ready), 1);
        check("out_b_retain", 32'(bus.out_b), 32'(b));
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_m      = '0;
        bus.in_e      = '0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_b", 32'(bus.out_b), 0);
        check("rst_noncanon", 32'(bus.out_noncanon), 0);
        check("rst_state", 32'(fsm_state), 32'(IDLE));
        rst = 1'b0;

        // Directed conversions
        convert(4'b1011, 3'd3, 0, 1'b1, 1'b0);   // 88
        convert(4'b1111, 3'd7, 0, 1'b1, 1'b0);   // 1920
        convert(4'b0101, 3'd0, 0, 1'b1, 1'b0);   // 5, canonical
        convert(4'b0101, 3'd2, 0, 1'b1, 1'b0);   // 20, noncanonical

        // Backpressure in DONE with junk input while busy
        convert(4'b1100, 3'd4, 5, 1'b0, 1'b1);   // 192
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_extra_result", 32'(bus.out_valid), 0);
        end

        // Reset in the middle of SHIFT
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_m     = 4'b1000;
        bus.in_e     = 3'd6;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_state_shift", 32'(fsm_state), 32'(SHIFT));
        rst = 1'b1;
        #1;
        check("abort_out_valid", 32'(bus.out_valid), 0);
        check("abort_in_ready", 32'(bus.in_ready), 1);
        check("abort_state", 32'(fsm_state), 32'(IDLE));
        check("abort_out_b", 32'(bus.out_b), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("abort_no_output", 32'(bus.out_valid), 0);
        end
        convert(4'b1000, 3'd1, 0, 1'b1, 1'b0);   // 16

        // Exhaustive over every {E, M} with random consumer behaviour
        for (int e = 0; e < 8; e++) begin
            for (int m = 0; m < 16; m++) begin
                convert(MW'(m), EW'(e), int'($urandom_range(0, 3)),
                        bit'($urandom_range(0, 1)), 1'b0);
            end
        end

        check("sb_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
